// File: rtl/nios_processor_keys_if.sv
`default_nettype none
// ============================================================================
//  Module      : nios_processor_keys_if
//  Description : Avalon-MM s1 slave bundle (address/strobe/data/irq) shared
//                between the interconnect and the key input PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nios_processor_keys_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/nios_processor_keys.sv
`default_nettype none
// ============================================================================
//  Module      : nios_processor_keys
//  Description : Avalon-MM input PIO for push-buttons. Two-flop synchroniser,
//                per-bit debounce, edge capture with W1C and a maskable
//                level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_processor_keys #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}},
  parameter int               EDGE_TYPE       = 1
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  nios_processor_keys_if.slave  s1,
  input  wire logic [WIDTH-1:0] in_port
);

  // A one-cycle debounce still needs a 1-bit counter to keep widths legal.
  localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_DIR  = 2'd1;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic             w_wr;

  assign w_wr = s1.chipselect & ~s1.write_n;

  // Two-flop synchroniser; resets to the idle level so no phantom press appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable_b;

    // Debounce: a new level must persist D consecutive cycles; any return resets the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt      <= '0;
        r_stable_b <= IDLE_LEVEL[i];
      end else if (r_sync2[i] == r_stable_b) begin
        r_cnt      <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_stable_b <= r_sync2[i];
        r_cnt      <= '0;
      end else begin
        r_cnt      <= r_cnt + 1'b1;
      end
    end

    assign w_stable[i] = r_stable_b;
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable_d <= IDLE_LEVEL;
    else          r_stable_d <= w_stable;
  end

  assign w_rise = w_stable & ~r_stable_d;
  assign w_fall = ~w_stable & r_stable_d;

  // Pick which transitions are captured.
  always_comb begin
    w_edge = w_rise | w_fall;
    case (EDGE_TYPE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise | w_fall;
    endcase
  end

  assign w_clear = (w_wr && s1.address == c_ADDR_EDGE) ? s1.writedata[WIDTH-1:0] : '0;

  // Mask register and edge latches; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
    end else begin
      if (w_wr && s1.address == c_ADDR_MASK) r_irq_mask <= s1.writedata[WIDTH-1:0];
      r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
    end
  end

  // Zero-latency read mux; upper bits stay zero.
  always_comb begin
    s1.readdata = '0;
    case (s1.address)
      c_ADDR_DATA: s1.readdata[WIDTH-1:0] = w_stable;
      c_ADDR_DIR:  s1.readdata            = '0;
      c_ADDR_MASK: s1.readdata[WIDTH-1:0] = r_irq_mask;
      c_ADDR_EDGE: s1.readdata[WIDTH-1:0] = r_edge_capture;
      default:     s1.readdata            = '0;
    endcase
  end

  assign s1.irq = |(r_edge_capture & r_irq_mask);

  if (WIDTH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, s1.writedata[31:WIDTH]};
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_processor_keys.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_processor_keys
//  Description : Directed self-checking bench for the key input PIO
//                (D=4, falling-edge capture).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_processor_keys;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  int         n_tests;
  int         n_fail;

  nios_processor_keys_if bus ();

  nios_processor_keys #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .IDLE_LEVEL      (4'hF),
    .EDGE_TYPE       (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s1      (bus.slave),
    .in_port (in_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, actual=running required=done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    chk(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset_n        = 1'b1;
    in_port        = 4'hF;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // 1: asynchronous reset asserted mid-cycle
    tick(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    rd_chk("reset_data", 2'd0, 32'h0000_000F);
    rd_chk("reset_mask", 2'd2, 32'h0);
    rd_chk("reset_edge", 2'd3, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // 3 setup: unmask key0
    bus_write(2'd2, 32'h1);
    rd_chk("mask_rb", 2'd2, 32'h1);

    // 2: press key0; sampled at tick 1, stable exactly 5 edges later
    in_port = 4'hE;
    tick(5);
    rd_chk("deb_before", 2'd0, 32'hF);
    tick(1);
    rd_chk("deb_after", 2'd0, 32'hE);
    rd_chk("edge_not_yet", 2'd3, 32'h0);
    tick(1);
    rd_chk("edge_key0", 2'd3, 32'h1);
    chk("irq_key0", {31'd0, bus.irq}, 32'd1);

    // 3: W1C clears capture and irq
    bus_write(2'd3, 32'h1);
    rd_chk("w1c_edge", 2'd3, 32'h0);
    chk("w1c_irq", {31'd0, bus.irq}, 32'd0);

    // release key0: rising edge is not captured
    in_port = 4'hF;
    tick(9);
    rd_chk("release_data", 2'd0, 32'hF);
    rd_chk("rise_ignored", 2'd3, 32'h0);

    // 2: three-cycle glitch never reaches stable
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd_chk("glitch_data", 2'd0, 32'hF);
    rd_chk("glitch_edge", 2'd3, 32'h0);

    // 4: press key1 while masked
    bus_write(2'd2, 32'h0);
    in_port = 4'hD;
    tick(8);
    rd_chk("key1_data", 2'd0, 32'hD);
    rd_chk("key1_edge", 2'd3, 32'h2);
    chk("key1_irq_masked", {31'd0, bus.irq}, 32'd0);
    bus_write(2'd2, 32'h2);
    chk("key1_irq_unmask", {31'd0, bus.irq}, 32'd1);

    // 5: W1C of bit0 on the very edge bit0's capture sets
    in_port = 4'hC;
    tick(6);
    rd_chk("coll_pre", 2'd3, 32'h2);
    bus_write(2'd3, 32'h1);
    rd_chk("coll_set_wins", 2'd3, 32'h3);

    // 6: writes to DATA/DIR have no effect
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    rd_chk("map_data", 2'd0, 32'hC);
    rd_chk("map_dir", 2'd1, 32'h0);
    rd_chk("map_mask", 2'd2, 32'h2);
    rd_chk("map_edge", 2'd3, 32'h3);
    chk("map_irq", {31'd0, bus.irq}, 32'd1);

    // reset mid-debounce: no capture on release
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    in_port = 4'hC;
    tick(2);
    rd_chk("rst_mid_data", 2'd0, 32'hF);
    rd_chk("rst_mid_edge", 2'd3, 32'h0);
    chk("rst_mid_irq", {31'd0, bus.irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
